dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port of the core between two requesters: requester 0 is the core load/store path, requester 1 is the debug/program-loader port.
- Accepts one access at a time and drives it to memory with a req/ack handshake.
- Returns the completion (read data or error) to the requester that was granted.
- Includes round-robin fairness, an ack timeout watchdog, and a saturating error counter.

Parameters:
ADDR_W, 32, address width per requester and on the memory side
TIMEOUT, 16, max cycles in ACCESS without mem_ack before the access is aborted with error (legal range 2..255)
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
m_req  in  2  per-requester access request; held with payload until own m_gnt bit seen high
m_we  in  2  per-requester write enable (1 = store, 0 = load)
m_addr  in  2*ADDR_W  per-requester address; requester n at bits [n*ADDR_W +: ADDR_W]
m_wdata  in  64  per-requester write data; requester n at bits [n*32 +: 32]
m_be  in  8  per-requester byte enables; requester n at bits [n*4 +: 4]
m_gnt  out  2  one-hot grant, one-cycle pulse
m_rvalid  out  2  one-hot completion, one-cycle pulse
m_rdata  out  32  read data; valid only while any m_rvalid bit is high
m_err  out  1  error flag (timeout); valid only while any m_rvalid bit is high
mem_req  out  1  memory request, held high through the whole access
mem_we  out  1  latched write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  32  latched write data
mem_be  out  4  latched byte enables
mem_ack  in  1  memory completion; meaningful only while mem_req = 1
mem_rdata  in  32  memory read data; sampled on the cycle mem_ack = 1
busy  out  1  high when state is not IDLE
err_count  out  8  saturating count of timed-out accesses

Behaviour:
- Registers: all outputs are registered.
- Reset (rst low, asynchronous): state = IDLE; every output = 0; last-winner pointer = 1, so requester 0 wins the first contest; timeout counter = 0; err_count = 0.
- Reset mid-operation: any in-flight access is dropped; no m_rvalid is issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - At an edge where m_req != 0, select the winner and go to ACCESS.
  - Winner selection: if only one bit is set, that requester wins. If both are set, RR_EN=1 picks the requester that is not the last winner; RR_EN=0 picks requester 0.
  - Capture the winner's we/addr/wdata/be into the mem_* registers.
- ACCESS:
  - mem_req = 1 with the captured payload held stable.
  - m_gnt[winner] = 1 on the first ACCESS cycle only.
  - The timeout counter starts at 0 and increments each cycle.
  - At an edge with mem_ack = 1: capture mem_rdata if the access is a read (write completions return rdata = 0), set err = 0, go to RESP.
  - Otherwise, if the counter = TIMEOUT-1: rdata = 0, err = 1, increment err_count (saturates at 255), go to RESP.
  - mem_ack arriving in the same cycle as the timeout: the ack wins and no error is raised.
- RESP:
  - mem_req = 0.
  - m_rvalid[winner] = 1 with m_rdata and m_err driven.
  - Last-winner pointer = winner.
  - Next state is IDLE unconditionally.
- Latency: request sampled at edge T → m_gnt and mem_req high in cycle T+1; mem_ack sampled at edge T+k → m_rvalid in cycle T+k+1. At most one access is in flight; back-to-back accesses are spaced at least 3 cycles apart.
- Ignored / dropped inputs:
  - mem_ack is ignored in IDLE and RESP.
  - m_req from the losing requester stays pending and is arbitrated at the next IDLE.
  - A requester that deasserts m_req before being granted is simply not served.
  - m_req from the winner during ACCESS/RESP is ignored; the requester deasserts after m_gnt.
- Outputs outside their windows: m_gnt and m_rvalid are never both nonzero for different requesters; m_rdata and m_err hold 0 whenever m_rvalid = 0.

Test Plan:
- Single read: m_req=2'b01, addr 0x100; memory acks 2 cycles after mem_req with 0xDEADBEEF → m_gnt=01 for 1 cycle; mem_addr=0x100 stable; m_rvalid=01 with m_rdata=0xDEADBEEF, m_err=0; busy for 4 cycles.
- Contention, RR_EN=1: both requesters hold m_req; memory acks immediately → grants alternate 01, 10, 01, 10; each grant is followed by a matching m_rvalid; no requester is starved.
- Contention, RR_EN=0: both requesters hold m_req → every grant goes to requester 0 while it keeps requesting; requester 1 is granted only after m_req[0] drops.
- Timeout: TIMEOUT=4, write from requester 1, mem_ack never asserted → mem_req high for exactly 4 cycles; then m_rvalid=10, m_err=1, m_rdata=0, err_count=1. Repeating 300 times → err_count stays at 255.
- Ack/timeout tie: TIMEOUT=4, mem_ack on the 4th ACCESS cycle → m_err=0, rdata captured, err_count unchanged.
- Reset mid-access: rst low during ACCESS → outputs 0 immediately; no m_rvalid after release; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]          m_req;
    logic [1:0]          m_we;
    logic [2*ADDR_W-1:0] m_addr;
    logic [63:0]         m_wdata;
    logic [7:0]          m_be;
    logic [1:0]          m_gnt;
    logic [1:0]          m_rvalid;
    logic [31:0]         m_rdata;
    logic                m_err;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_be;
    logic                mem_ack;
    logic [31:0]         mem_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be, mem_ack, mem_rdata,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be, mem_ack, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with ack watchdog and error counter
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int RR_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_arbiter_if.slave    bus,
    output logic             busy,
    output logic [7:0]       err_count
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              pick;

    // On contention the round-robin pointer favours whoever did not win last.
    always_comb begin
        pick = 1'b0;
        if (bus.m_req == 2'b10) begin
            pick = 1'b1;
        end else if (bus.m_req == 2'b11) begin
            pick = (RR_EN != 0) ? ~last_q : 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            S_IDLE: begin
                if (bus.m_req != 2'b00) begin
                    state_d     = S_ACCESS;
                    winner_d    = pick;
                    gnt_d       = pick ? 2'b10 : 2'b01;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.m_we[pick];
                    mem_addr_d  = pick ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
                    mem_wdata_d = pick ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
                    mem_be_d    = pick ? bus.m_be[7:4] : bus.m_be[3:0];
                end
            end
            S_ACCESS: begin
                // An ack on the final watchdog cycle still counts as a clean completion.
                if (bus.mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    rvalid_d  = winner_q ? 2'b10 : 2'b01;
                    rdata_d   = mem_we_q ? 32'd0 : bus.mem_rdata;
                    last_d    = winner_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    rvalid_d  = winner_q ? 2'b10 : 2'b01;
                    err_d     = 1'b1;
                    last_d    = winner_q;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            winner_q    <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            err_count_q <= 8'd0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign bus.m_gnt     = gnt_q;
    assign bus.m_rvalid  = rvalid_q;
    assign bus.m_rdata   = rdata_q;
    assign bus.m_err     = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign busy          = busy_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench: round-robin and fixed-priority arbiters in lockstep
module tb_dmem_arbiter;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  m_req = 2'b00;
    logic [1:0]  m_we = 2'b00;
    logic [63:0] m_addr = 64'd0;
    logic [63:0] m_wdata = 64'd0;
    logic [7:0]  m_be = 8'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy_rr, busy_fp;
    logic [7:0]  ec_rr, ec_fp;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) if_rr ();
    dmem_arbiter_if #(.ADDR_W(AW)) if_fp ();

    assign if_rr.m_req     = m_req;
    assign if_rr.m_we      = m_we;
    assign if_rr.m_addr    = m_addr;
    assign if_rr.m_wdata   = m_wdata;
    assign if_rr.m_be      = m_be;
    assign if_rr.mem_ack   = mem_ack;
    assign if_rr.mem_rdata = mem_rdata;
    assign if_fp.m_req     = m_req;
    assign if_fp.m_we      = m_we;
    assign if_fp.m_addr    = m_addr;
    assign if_fp.m_wdata   = m_wdata;
    assign if_fp.m_be      = m_be;
    assign if_fp.mem_ack   = mem_ack;
    assign if_fp.mem_rdata = mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .TIMEOUT(4), .RR_EN(1)) u_rr (
        .clk(clk), .rst(rst_n), .bus(if_rr.slave), .busy(busy_rr), .err_count(ec_rr));
    dmem_arbiter #(.ADDR_W(AW), .TIMEOUT(4), .RR_EN(0)) u_fp (
        .clk(clk), .rst(rst_n), .bus(if_fp.slave), .busy(busy_fp), .err_count(ec_fp));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; m_req = 2'b00; m_we = 2'b00; mem_ack = 1'b0; mem_rdata = 32'd0;
        m_addr = 64'd0; m_wdata = 64'd0; m_be = 8'd0;
        tick();
        check("rst_gnt", 64'(if_rr.m_gnt), 64'd0);
        check("rst_rvalid", 64'(if_rr.m_rvalid), 64'd0);
        check("rst_rdata", 64'(if_rr.m_rdata), 64'd0);
        check("rst_err", 64'(if_rr.m_err), 64'd0);
        check("rst_mem_req", 64'({if_rr.mem_req, if_fp.mem_req}), 64'd0);
        check("rst_mem_addr", 64'(if_rr.mem_addr), 64'd0);
        check("rst_busy", 64'({busy_rr, busy_fp}), 64'd0);
        check("rst_err_count", 64'({ec_rr, ec_fp}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input string tag);
        int k = 0;
        while (if_rr.m_gnt == 2'b00 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 64'(if_rr.m_gnt != 2'b00), 64'd1);
    endtask

    task automatic wait_rv(input string tag);
        int k = 0;
        while (if_rr.m_rvalid == 2'b00 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 64'(if_rr.m_rvalid != 2'b00), 64'd1);
    endtask

    initial begin
        logic [1:0] exp_g, exp_v;
        logic       seen_rv;
        int         nreq;

        // Single read from requester 0, ack on the third ACCESS cycle.
        apply_reset();
        m_req = 2'b01; m_we = 2'b00; m_addr = {32'h0000_0200, 32'h0000_0100}; m_be = 8'h0F;
        tick();
        check("rd_gnt", 64'(if_rr.m_gnt), 64'h1);
        check("rd_mem_req", 64'(if_rr.mem_req), 64'h1);
        check("rd_mem_addr", 64'(if_rr.mem_addr), 64'h100);
        check("rd_busy", 64'(busy_rr), 64'h1);
        m_req = 2'b00;
        tick();
        check("rd_gnt_pulse", 64'(if_rr.m_gnt), 64'h0);
        check("rd_addr_stable", 64'(if_rr.mem_addr), 64'h100);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        check("rd_rvalid", 64'(if_rr.m_rvalid), 64'h1);
        check("rd_rdata", 64'(if_rr.m_rdata), 64'hDEAD_BEEF);
        check("rd_err", 64'(if_rr.m_err), 64'h0);
        check("rd_mem_req_low", 64'(if_rr.mem_req), 64'h0);
        check("rd_busy_resp", 64'(busy_rr), 64'h1);
        tick();
        check("rd_idle_busy", 64'(busy_rr), 64'h0);
        check("rd_idle_rvalid", 64'(if_rr.m_rvalid), 64'h0);
        check("rd_idle_rdata", 64'(if_rr.m_rdata), 64'h0);

        // Contention with immediate ack: 3-cycle period ACCESS, RESP, IDLE.
        apply_reset();
        m_req = 2'b11; m_we = 2'b00; m_addr = {32'h0000_2000, 32'h0000_1000};
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_g = 2'b00;
            exp_v = 2'b00;
            if (c % 3 == 1) exp_g = (((c - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
            if (c % 3 == 2) exp_v = (((c - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("rr_gnt_c%0d", c), 64'(if_rr.m_gnt), 64'(exp_g));
            check($sformatf("rr_rvalid_c%0d", c), 64'(if_rr.m_rvalid), 64'(exp_v));
            check($sformatf("fp_gnt_c%0d", c), 64'(if_fp.m_gnt), (c % 3 == 1) ? 64'h1 : 64'h0);
            check($sformatf("fp_rvalid_c%0d", c), 64'(if_fp.m_rvalid), (c % 3 == 2) ? 64'h1 : 64'h0);
            if (c % 3 == 1)
                check($sformatf("rr_addr_c%0d", c), 64'(if_rr.mem_addr),
                      (exp_g == 2'b10) ? 64'h2000 : 64'h1000);
            if (c % 3 == 2)
                check($sformatf("rr_rdata_c%0d", c), 64'(if_rr.m_rdata), 64'hA5A5_0000);
        end
        m_req = 2'b10;
        tick();
        check("fp_gnt_after_drop", 64'(if_fp.m_gnt), 64'h2);
        check("fp_addr_after_drop", 64'(if_fp.mem_addr), 64'h2000);
        m_req = 2'b00;
        tick();
        tick();
        mem_ack = 1'b0;

        // Write from requester 1 that is never acked times out after 4 cycles.
        apply_reset();
        m_req = 2'b10; m_we = 2'b10; m_addr = {32'h0000_0200, 32'h0000_0300};
        m_wdata = {32'hCAFE_F00D, 32'h1111_1111}; m_be = 8'hC3;
        tick();
        m_req = 2'b00;
        check("to_mem_we", 64'(if_rr.mem_we), 64'h1);
        check("to_mem_addr", 64'(if_rr.mem_addr), 64'h200);
        check("to_mem_wdata", 64'(if_rr.mem_wdata), 64'hCAFE_F00D);
        check("to_mem_be", 64'(if_rr.mem_be), 64'hC);
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (if_rr.m_rvalid != 2'b00) break;
            if (if_rr.mem_req) nreq++;
            tick();
        end
        check("to_mem_req_cycles", 64'(nreq), 64'd4);
        check("to_rvalid", 64'(if_rr.m_rvalid), 64'h2);
        check("to_err", 64'(if_rr.m_err), 64'h1);
        check("to_rdata", 64'(if_rr.m_rdata), 64'h0);
        check("to_err_count", 64'(ec_rr), 64'd1);
        for (int i = 2; i <= 300; i++) begin
            m_req = 2'b10;
            wait_gnt($sformatf("to_rep_gnt_%0d", i));
            m_req = 2'b00;
            wait_rv($sformatf("to_rep_rv_%0d", i));
            if (i == 254) check("to_err_count_254", 64'(ec_rr), 64'd254);
        end
        check("to_err_count_sat_rr", 64'(ec_rr), 64'd255);
        check("to_err_count_sat_fp", 64'(ec_fp), 64'd255);
        tick();

        // Ack arrives on the 4th ACCESS cycle, the same cycle the watchdog would fire.
        apply_reset();
        m_req = 2'b01; m_we = 2'b00; m_addr = {32'h0, 32'h0000_0400};
        tick();
        m_req = 2'b00;
        tick();
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h600D_F00D;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        check("tie_rvalid", 64'(if_rr.m_rvalid), 64'h1);
        check("tie_err", 64'(if_rr.m_err), 64'h0);
        check("tie_rdata", 64'(if_rr.m_rdata), 64'h600D_F00D);
        check("tie_err_count", 64'(ec_rr), 64'd0);
        tick();

        // Reset during ACCESS after requester 0 has already won once.
        apply_reset();
        m_req = 2'b01; mem_ack = 1'b1; mem_rdata = 32'h11;
        tick();
        m_req = 2'b00;
        tick();
        tick();
        mem_ack = 1'b0;
        m_req = 2'b01; m_addr = {32'h0, 32'h0000_0500};
        tick();
        check("mid_mem_req_before", 64'(if_rr.mem_req), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_mem_req", 64'(if_rr.mem_req), 64'h0);
        check("mid_busy", 64'(busy_rr), 64'h0);
        check("mid_mem_addr", 64'(if_rr.mem_addr), 64'h0);
        m_req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        seen_rv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (if_rr.m_rvalid != 2'b00) seen_rv = 1'b1;
        end
        check("mid_no_rvalid", 64'(seen_rv), 64'h0);
        m_req = 2'b11;
        tick();
        check("mid_first_gnt", 64'(if_rr.m_gnt), 64'h1);
        m_req = 2'b00;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
